// File: rtl/write_demux.sv
// write_demux: single-entry registered write demultiplexer.
// Accepts one (address, data) write on a valid/ready port and presents it to
// exactly one of DATA_DEPTH destination slots on a one-hot valid bus with
// per-slot ready. Idle data is all-zero so an OR-combining read side is unaffected.
// Optional feature macro: WDEMUX_BROADCAST_EN adds a broadcast_i input that writes
// the held word to every slot, each slot accepting independently.
module write_demux #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = (1 << ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  write_valid_i,
  output logic                  write_ready_o,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef WDEMUX_BROADCAST_EN
  input  logic                  broadcast_i,
`endif
  output logic [DATA_DEPTH-1:0] write_valid_o,
  input  logic [DATA_DEPTH-1:0] write_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_DEPTH-1:0]   onehot;
  logic                    done;
  logic                    transfer;

`ifdef WDEMUX_BROADCAST_EN
  // Broadcast bookkeeping: which slots still have to take the held word.
  logic                    bcast_reg;
  logic [DATA_DEPTH-1:0]   pending_reg;
`endif

  // Address decode of the held slot index into the one-hot slot vector.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_DEPTH; gi++) begin : g_decode
      assign onehot[gi] = (addr_reg == ADDR_WIDTH'(gi));
    end
  endgenerate

  // The held write completes when its destination(s) have all taken it.
  always_comb begin
    done = 1'b0;
    if (state_reg == SEND) begin
`ifdef WDEMUX_BROADCAST_EN
      if (bcast_reg) begin
        done = ((pending_reg & ~write_ready_i) == '0);
      end else begin
        done = write_ready_i[addr_reg];
      end
`else
      done = write_ready_i[addr_reg];
`endif
    end
  end

  // Upstream may hand over a new write when the stage is empty or draining now;
  // forced low while reset is asserted.
  assign write_ready_o = rst_ni && ((state_reg == IDLE) || done);
  assign transfer      = write_valid_i && write_ready_o;
  assign busy_o        = (state_reg == SEND);

  // Slot-side outputs: zero when idle, held word while sending.
  always_comb begin
    write_valid_o = '0;
    data_o        = '0;
    if (state_reg == SEND) begin
      data_o = data_reg;
`ifdef WDEMUX_BROADCAST_EN
      if (bcast_reg) begin
        write_valid_o = pending_reg;
      end else begin
        write_valid_o = onehot;
      end
`else
      write_valid_o = onehot;
`endif
    end
  end

  // Control FSM and held-write capture; a back-to-back transfer reloads while
  // staying in SEND so throughput is one write per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
`ifdef WDEMUX_BROADCAST_EN
      bcast_reg   <= 1'b0;
      pending_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (!transfer && done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (transfer) begin
        addr_reg <= write_addr_i;
        data_reg <= data_i;
      end

`ifdef WDEMUX_BROADCAST_EN
      // Each slot is written once: a ready slot drops out of the pending mask.
      if (transfer) begin
        bcast_reg   <= broadcast_i;
        pending_reg <= broadcast_i ? '1 : '0;
      end else if (state_reg == SEND) begin
        pending_reg <= pending_reg & ~write_ready_i;
      end
`endif
    end
  end

endmodule
